// File: rtl/regfile_pkg.sv
// Shared definitions for the general-purpose register file: bus types,
// well-known constants and the clear/run FSM encoding.
package regfile_pkg;

  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  typedef logic [31:0]           RegBus;
  typedef logic [RegNumLog2-1:0] RegAddrBus;

  localparam RegBus     ZeroWord   = 32'h0000_0000;
  localparam RegAddrBus NOPRegAddr = '0;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;
  localparam logic ReadDisable = 1'b0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mem.sv
// Register storage: one synchronous write port, two asynchronous read ports,
// no reset so it maps onto a plain RAM array.
module regfile_mem #(
  parameter int REG_NUM    = 32,
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [REG_WIDTH-1:0]  wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [REG_WIDTH-1:0]  rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [REG_WIDTH-1:0]  rdata2
);

  logic [REG_WIDTH-1:0] mem [REG_NUM];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/regfile.sv
// 32 x 32 register file with r0 tied to zero, post-reset clear sweep that
// stalls the pipeline, and same-cycle write-through bypass on both read ports.
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM    = RegNum,
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = RegNumLog2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [REG_WIDTH-1:0]  wdata,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [REG_WIDTH-1:0]  rdata1,
  input  logic                  re2,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [REG_WIDTH-1:0]  rdata2,
  output logic                  stallreq
);

  rf_state_e             state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  run;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [REG_WIDTH-1:0]  mem_wdata;
  logic [REG_WIDTH-1:0]  mem_rdata1;
  logic [REG_WIDTH-1:0]  mem_rdata2;

  // r0 is never written, so the sweep starts at 1 and ends at REG_NUM-1.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= RF_CLEAR;
      idx   <= ADDR_WIDTH'(1);
    end else if (state == RF_CLEAR) begin
      idx <= idx + ADDR_WIDTH'(1);
      if (idx == ADDR_WIDTH'(REG_NUM - 1)) begin
        state <= RF_RUN;
      end
    end
  end

  assign run      = (state == RF_RUN) && (rst != RstEnable);
  assign stallreq = (state == RF_CLEAR) || (rst == RstEnable);

  // Sweep owns the write port until RUN; write-back writes are dropped meanwhile.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (rst != RstEnable) begin
      if (state == RF_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = idx;
        mem_wdata = REG_WIDTH'(ZeroWord);
      end else begin
        mem_we = (we == WriteEnable) && (waddr != ADDR_WIDTH'(NOPRegAddr));
      end
    end
  end

  regfile_mem #(
    .REG_NUM   (REG_NUM),
    .REG_WIDTH (REG_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr1(raddr1),
    .rdata1(mem_rdata1),
    .raddr2(raddr2),
    .rdata2(mem_rdata2)
  );

  function automatic logic [REG_WIDTH-1:0] read_port(
    input logic                  is_run,
    input logic                  re,
    input logic [ADDR_WIDTH-1:0] raddr,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [REG_WIDTH-1:0]  wr_data,
    input logic [REG_WIDTH-1:0]  mem_data
  );
    logic [REG_WIDTH-1:0] res;
    res = REG_WIDTH'(ZeroWord);
    if (is_run && (raddr != ADDR_WIDTH'(NOPRegAddr)) && (re == ReadEnable)) begin
      if ((wr_en == WriteEnable) && (wr_addr == raddr)) begin
        res = wr_data;
      end else begin
        res = mem_data;
      end
    end
    return res;
  endfunction

  assign rdata1 = read_port(run, re1, raddr1, we, waddr, wdata, mem_rdata1);
  assign rdata2 = read_port(run, re2, raddr2, we, waddr, wdata, mem_rdata2);

endmodule
